wb_arbiter: RTL and testbench

Parametrised N-master to one-slave Wishbone (classic, single-beat) arbiter with round-robin grant and a per-cycle slave timeout. It sits between bus masters (LIMB interface, CPU bus front-end, PCI initiator) and a shared Wishbone slave (`wb_ram` now, the DDR3 controller port later). The arbiter replaces the point-to-point LIMB-to-RAM hookup. A master keeps its grant for the whole `cyc` assertion, and a hung slave is cut off with `err` instead of stalling the bus.

---
 rtl/wb_arbiter.sv | 120 ++++++++++++
 tb/tb_wb_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// N-master to one-slave classic Wishbone arbiter: round-robin grant held for the
// whole cyc assertion, with an optional per-beat slave timeout that forces err.
module wb_arbiter #(
  parameter int unsigned NMASTERS   = 2,
  parameter int unsigned ADDR_WIDTH = 36,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NMASTERS-1:0]                m_cyc_i,
  input  logic [NMASTERS-1:0]                m_stb_i,
  input  logic [NMASTERS-1:0]                m_we_i,
  input  logic [NMASTERS*(DATA_WIDTH/8)-1:0] m_sel_i,
  input  logic [NMASTERS*ADDR_WIDTH-1:0]     m_adr_i,
  input  logic [NMASTERS*DATA_WIDTH-1:0]     m_dat_i,
  output logic [DATA_WIDTH-1:0]              m_dat_o,
  output logic [NMASTERS-1:0]                m_ack_o,
  output logic [NMASTERS-1:0]                m_err_o,
  output logic                               s_cyc_o,
  output logic                               s_stb_o,
  output logic                               s_we_o,
  output logic [DATA_WIDTH/8-1:0]            s_sel_o,
  output logic [ADDR_WIDTH-1:0]              s_adr_o,
  output logic [DATA_WIDTH-1:0]              s_dat_o,
  input  logic [DATA_WIDTH-1:0]              s_dat_i,
  input  logic                               s_ack_i,
  input  logic                               s_err_i,
  output logic [NMASTERS-1:0]                grant_o
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IW        = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
  localparam int unsigned TW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(NMASTERS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q;
  logic [IW-1:0] owner_q, last_q;
  logic [TW-1:0] tcnt_q, tcnt_d;

  logic          busy, cyc_own, stb_raw, tout, found;
  logic [IW-1:0] pick;
  int unsigned   idx;

  // Round-robin search starting just after the last winner.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= NMASTERS; i++) begin
      idx = 32'(last_q) + i;
      if (idx >= NMASTERS) idx = idx - NMASTERS;
      if (!found && m_cyc_i[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    busy    = (state_q == BUSY);
    cyc_own = m_cyc_i[owner_q];
    stb_raw = busy && cyc_own && m_stb_i[owner_q];
    tout    = (TIMEOUT != 0) && stb_raw && (tcnt_q == TW'(TIMEOUT));
    tcnt_d  = ((TIMEOUT != 0) && stb_raw && !s_ack_i && !s_err_i && !tout)
              ? tcnt_q + 1'b1 : '0;

    grant_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_dat_o = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (busy) begin
      grant_o[owner_q] = 1'b1;
      s_cyc_o          = cyc_own;
      s_stb_o          = stb_raw && !tout;
      s_we_o           = m_we_i[owner_q];
      s_sel_o          = m_sel_i[owner_q*SEL_WIDTH +: SEL_WIDTH];
      s_adr_o          = m_adr_i[owner_q*ADDR_WIDTH +: ADDR_WIDTH];
      s_dat_o          = m_dat_i[owner_q*DATA_WIDTH +: DATA_WIDTH];
      m_dat_o          = s_dat_i;
      // err wins over a simultaneous ack, and a forced timeout masks the slave ack
      m_ack_o[owner_q] = s_ack_i && !s_err_i && !tout;
      m_err_o[owner_q] = s_err_i || tout;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      tcnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tcnt_q <= '0;
          if (found) begin
            owner_q <= pick;
            last_q  <= pick;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          tcnt_q <= tcnt_d;
          if (!cyc_own) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a 3-master/TIMEOUT=4 instance driven by a cycle table and a
// 2-master/no-timeout instance driving a small RAM slave through hand-written sequences.
module tb_wb_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nbad = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- DUT A: 3 masters, TIMEOUT=4 ----------------
  logic         rst_a;
  logic [2:0]   a_cyc, a_stb, a_we, a_ack, a_err, a_gnt;
  logic [11:0]  a_sel;
  logic [107:0] a_adr;
  logic [95:0]  a_dat;
  logic [31:0]  a_mdat, a_sdat, a_sdi;
  logic         a_scyc, a_sstb, a_swe, a_sack, a_serr;
  logic [3:0]   a_ssel;
  logic [35:0]  a_sadr;

  wb_arbiter #(.NMASTERS(3), .ADDR_WIDTH(36), .DATA_WIDTH(32), .TIMEOUT(4)) dut_a (
    .clk(clk), .reset(rst_a),
    .m_cyc_i(a_cyc), .m_stb_i(a_stb), .m_we_i(a_we), .m_sel_i(a_sel),
    .m_adr_i(a_adr), .m_dat_i(a_dat), .m_dat_o(a_mdat), .m_ack_o(a_ack), .m_err_o(a_err),
    .s_cyc_o(a_scyc), .s_stb_o(a_sstb), .s_we_o(a_swe), .s_sel_o(a_ssel),
    .s_adr_o(a_sadr), .s_dat_o(a_sdat), .s_dat_i(a_sdi), .s_ack_i(a_sack), .s_err_i(a_serr),
    .grant_o(a_gnt)
  );

  // ---------------- DUT B: 2 masters, timeout disabled ----------------
  logic        rst_b;
  logic [1:0]  b_cyc, b_stb, b_we, b_ack, b_err, b_gnt;
  logic [7:0]  b_sel;
  logic [71:0] b_adr;
  logic [63:0] b_dat;
  logic [31:0] b_mdat, b_sdat, b_sdi;
  logic        b_scyc, b_sstb, b_swe, b_sack, b_serr;
  logic [3:0]  b_ssel;
  logic [35:0] b_sadr;

  wb_arbiter #(.NMASTERS(2), .ADDR_WIDTH(36), .DATA_WIDTH(32), .TIMEOUT(0)) dut_b (
    .clk(clk), .reset(rst_b),
    .m_cyc_i(b_cyc), .m_stb_i(b_stb), .m_we_i(b_we), .m_sel_i(b_sel),
    .m_adr_i(b_adr), .m_dat_i(b_dat), .m_dat_o(b_mdat), .m_ack_o(b_ack), .m_err_o(b_err),
    .s_cyc_o(b_scyc), .s_stb_o(b_sstb), .s_we_o(b_swe), .s_sel_o(b_ssel),
    .s_adr_o(b_sadr), .s_dat_o(b_sdat), .s_dat_i(b_sdi), .s_ack_i(b_sack), .s_err_i(b_serr),
    .grant_o(b_gnt)
  );

  // RAM slave for DUT B: registered ack one cycle after stb, one beat per two cycles.
  logic [31:0] mem [16];
  logic        b_ackq, b_slv_en, b_frc_ack;
  logic [31:0] b_rd;

  always @(posedge clk) begin
    if (b_slv_en && b_scyc && b_sstb && !b_ackq) begin
      b_ackq <= 1'b1;
      b_rd   <= mem[b_sadr[5:2]];
      if (b_swe)
        for (int j = 0; j < 4; j++)
          if (b_ssel[j]) mem[b_sadr[5:2]][j*8 +: 8] <= b_sdat[j*8 +: 8];
    end else begin
      b_ackq <= 1'b0;
    end
  end

  assign b_sack = (b_ackq && b_sstb) || b_frc_ack;
  assign b_serr = 1'b0;
  assign b_sdi  = b_rd;

  task automatic b_beat(input int k, input logic we, input logic [35:0] adr,
                        input logic [31:0] dat, output logic [31:0] rd,
                        output logic [1:0] g, output logic ok);
    b_stb[k]             = 1'b1;
    b_we[k]              = we;
    b_adr[k*36 +: 36]    = adr;
    b_dat[k*32 +: 32]    = dat;
    b_sel[k*4 +: 4]      = 4'hF;
    ok = 1'b0;
    rd = '0;
    g  = '0;
    for (int c = 0; c < 30 && !ok; c++) begin
      @(negedge clk);
      if (b_ack[k]) begin
        ok = 1'b1;
        rd = b_mdat;
        g  = b_gnt;
      end
    end
    @(posedge clk);
    #1;
    b_stb[k] = 1'b0;
  endtask

  // ---------------- cycle table for DUT A ----------------
  typedef struct packed {
    logic [2:0] cyc, stb;
    logic       ack, err;
    logic [2:0] gnt, mack, merr;
    logic       scyc, sstb;
  } vec_t;

  function automatic vec_t v(input logic [2:0] c, s, input logic a, e,
                             input logic [2:0] g, ma, me, input logic sc, ss);
    return '{cyc: c, stb: s, ack: a, err: e, gnt: g, mack: ma, merr: me, scyc: sc, sstb: ss};
  endfunction

  vec_t tbl [21];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  g;
    logic        ok;
    int          bad_cnt;
    logic [31:0] wdat [4];
    logic [35:0] wadr [4];

    //            cyc     stb    ack  err   gnt     mack    merr   scyc sstb
    tbl[0]  = v(3'b000, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 0, 0);
    tbl[1]  = v(3'b011, 3'b011, 0, 0, 3'b000, 3'b000, 3'b000, 0, 0);
    tbl[2]  = v(3'b011, 3'b011, 1, 0, 3'b001, 3'b001, 3'b000, 1, 1);
    tbl[3]  = v(3'b010, 3'b010, 0, 0, 3'b001, 3'b000, 3'b000, 0, 0);
    tbl[4]  = v(3'b110, 3'b110, 0, 0, 3'b000, 3'b000, 3'b000, 0, 0);
    tbl[5]  = v(3'b110, 3'b110, 1, 1, 3'b010, 3'b000, 3'b010, 1, 1);
    tbl[6]  = v(3'b100, 3'b100, 0, 0, 3'b010, 3'b000, 3'b000, 0, 0);
    tbl[7]  = v(3'b101, 3'b101, 0, 0, 3'b000, 3'b000, 3'b000, 0, 0);
    tbl[8]  = v(3'b101, 3'b101, 1, 0, 3'b100, 3'b100, 3'b000, 1, 1);
    tbl[9]  = v(3'b001, 3'b001, 0, 0, 3'b100, 3'b000, 3'b000, 0, 0);
    tbl[10] = v(3'b001, 3'b001, 0, 0, 3'b000, 3'b000, 3'b000, 0, 0);
    tbl[11] = v(3'b001, 3'b001, 0, 0, 3'b001, 3'b000, 3'b000, 1, 1);
    tbl[12] = v(3'b001, 3'b001, 0, 0, 3'b001, 3'b000, 3'b000, 1, 1);
    tbl[13] = v(3'b001, 3'b001, 0, 0, 3'b001, 3'b000, 3'b000, 1, 1);
    tbl[14] = v(3'b001, 3'b001, 0, 0, 3'b001, 3'b000, 3'b000, 1, 1);
    tbl[15] = v(3'b001, 3'b001, 0, 0, 3'b001, 3'b000, 3'b001, 1, 0);
    tbl[16] = v(3'b001, 3'b001, 0, 0, 3'b001, 3'b000, 3'b000, 1, 1);
    tbl[17] = v(3'b001, 3'b000, 0, 0, 3'b001, 3'b000, 3'b000, 1, 0);
    tbl[18] = v(3'b001, 3'b001, 1, 0, 3'b001, 3'b001, 3'b000, 1, 1);
    tbl[19] = v(3'b000, 3'b000, 0, 0, 3'b001, 3'b000, 3'b000, 0, 0);
    tbl[20] = v(3'b000, 3'b000, 1, 1, 3'b000, 3'b000, 3'b000, 0, 0);

    wadr[0] = 36'h4; wdat[0] = 32'hDEADBEEF;
    wadr[1] = 36'h0; wdat[1] = 32'h11112222;
    wadr[2] = 36'h8; wdat[2] = 32'h33334444;
    wadr[3] = 36'hC; wdat[3] = 32'h55556666;

    rst_a = 1'b1; rst_b = 1'b1;
    a_cyc = '0; a_stb = '0; a_we = 3'b010; a_sack = 1'b0; a_serr = 1'b0;
    a_sel = 12'hFFF; a_adr = {36'h300, 36'h200, 36'h100}; a_dat = {32'h3, 32'h2, 32'h1};
    a_sdi = 32'hA5A5A5A5;
    b_cyc = '0; b_stb = '0; b_we = '0; b_sel = '0; b_adr = '0; b_dat = '0;
    b_slv_en = 1'b1; b_frc_ack = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;

    for (int i = 0; i < 21; i++) begin
      a_cyc  = tbl[i].cyc;
      a_stb  = tbl[i].stb;
      a_sack = tbl[i].ack;
      a_serr = tbl[i].err;
      @(negedge clk);
      chk($sformatf("vecA[%0d]", i),
          {a_gnt, a_ack, a_err, a_scyc, a_sstb},
          {tbl[i].gnt, tbl[i].mack, tbl[i].merr, tbl[i].scyc, tbl[i].sstb});
      @(posedge clk);
      #1;
    end

    // First grant with simultaneous requests, then master 0 writes while master 1 waits.
    b_cyc = 2'b11;
    @(posedge clk);
    @(negedge clk);
    chk("first_grant", b_gnt, 2'b01);
    for (int i = 0; i < 4; i++) begin
      b_beat(0, 1'b1, wadr[i], wdat[i], rd, g, ok);
      chk($sformatf("wr_ack[%0d]", i), ok, 1'b1);
      chk($sformatf("wr_grant[%0d]", i), g, 2'b01);
      if (i == 0) begin
        @(negedge clk);
        chk("ack_one_cycle", b_ack, 2'b00);
        @(posedge clk);
        #1;
      end
    end

    b_cyc[0] = 1'b0;
    @(negedge clk);
    chk("rel0_busy", {b_gnt, b_scyc}, {2'b01, 1'b0});
    @(negedge clk);
    chk("rel0_dead", b_gnt, 2'b00);
    @(negedge clk);
    chk("rel0_next", b_gnt, 2'b10);

    // Master 1 burst of reads while master 0 is requesting again.
    @(posedge clk);
    #1;
    b_cyc[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_beat(1, 1'b0, 36'(i * 4), 32'h0, rd, g, ok);
      chk($sformatf("rd_ack[%0d]", i), ok, 1'b1);
      chk($sformatf("rd_grant[%0d]", i), g, 2'b10);
      chk($sformatf("rd_data[%0d]", i), rd,
          (i == 0) ? 32'h11112222 : (i == 1) ? 32'hDEADBEEF :
          (i == 2) ? 32'h33334444 : 32'h55556666);
    end
    b_cyc[1] = 1'b0;
    @(negedge clk);
    chk("rel1_busy", b_gnt, 2'b10);
    @(negedge clk);
    chk("rel1_dead", b_gnt, 2'b00);
    @(negedge clk);
    chk("rel1_next", b_gnt, 2'b01);

    // TIMEOUT=0: silent slave, no error may ever appear.
    @(posedge clk);
    #1;
    b_slv_en = 1'b0;
    b_stb[0] = 1'b1;
    bad_cnt = 0;
    repeat (1000) begin
      @(negedge clk);
      if (b_err != 2'b00 || !b_sstb) bad_cnt++;
    end
    chk("no_timeout", bad_cnt, 0);

    // Reset while BUSY with stb high: everything drops at once.
    @(posedge clk);
    #2;
    b_cyc     = 2'b11;
    b_frc_ack = 1'b1;
    rst_b     = 1'b1;
    #1;
    chk("mid_reset_outputs",
        {b_gnt, b_ack, b_err, b_scyc, b_sstb, b_swe, b_ssel, b_sadr, b_sdat, b_mdat}, '0);
    @(posedge clk);
    #2;
    rst_b     = 1'b0;
    b_frc_ack = 1'b0;
    b_stb     = '0;
    b_slv_en  = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", b_gnt, 2'b00);
    @(negedge clk);
    chk("post_reset_grant", b_gnt, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
